uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte FIFO and frame pacer directly upstream of the simplex UART transmitter.
//  Buffers bytes from producers (VGA/debug logic) and issues one-cycle send strobes plus frame data.
//  The UART has no busy output, so spacing between sends is fixed by a local slot timer.
// PARAMETERS
//  TicksPerBit  434  clocks per UART bit (50 MHz / 115200); must match the UART instance
//  Depth        16   FIFO entries; power of 2, >= 2
//  GuardTicks   2    extra idle clocks per slot beyond one 10-bit frame; >= 1
//  Derived: SlotTicks = 10*TicksPerBit + GuardTicks
// PORTS
//  CLK          in   1   system clock
//  RST          in   1   synchronous reset, active-high
//  i_wr_valid   in   1   producer write request
//  i_wr_data    in   8   byte to enqueue
//  o_wr_ready   out  1   FIFO not full; write accepted when i_wr_valid && o_wr_ready
//  o_send       out  1   one-cycle strobe to UART i_send
//  o_frame      out  8   byte to UART i_frame; held stable between strobes
//  o_count      out  $clog2(Depth)+1  current FIFO occupancy
//  o_busy       out  1   state != IDLE || o_count != 0
//  o_overflow   out  1   sticky drop flag (only with UART_TX_FEEDER_OVF_EN)
// BEHAVIOUR
//  - Reset: o_send=0, o_frame=8'h00, o_count=0, o_wr_ready=1, o_busy=0, pointers=0,
//    timer=0, state=IDLE, o_overflow=0. Reset mid-slot aborts the slot and discards FIFO contents.
//  - FIFO: circular buffer, rd/wr pointers $clog2(Depth) bits, wrap naturally at Depth.
//    o_wr_ready = (o_count != Depth), combinational from the registered count.
//    No fall-through: a byte written in cycle N is first poppable in cycle N+1.
//  - Simultaneous push and pop: count unchanged. When full, push is refused even if a pop occurs
//    in the same cycle.
//  - FSM:
//    IDLE: if o_count != 0 at the clock edge, load o_frame <= mem[rd], set o_send <= 1,
//      advance rd, decrement count, clear timer, go to WAIT. Otherwise o_send stays 0.
//    WAIT: o_send <= 0; timer increments. When timer == SlotTicks-1, go to IDLE.
//  - o_send is high for exactly one cycle. Minimum spacing between strobes is SlotTicks+1 cycles,
//    which exceeds the UART's 10*TicksPerBit+1 busy window.
//  - Latency: a write with i_wr_valid high in cycle 0 into an empty, idle FIFO produces
//    o_send=1 with the byte on o_frame in cycle 2.
//  - Order: strict FIFO. No byte is duplicated or skipped.
//  - Timer width: $clog2(SlotTicks). The timer never wraps; it always resets to 0 on entry to WAIT.
// CONFIGURATION
//  UART_TX_FEEDER_OVF_EN defined:
//   - o_overflow port exists.
//   - Set to 1 on the clock after any cycle with i_wr_valid && !o_wr_ready.
//   - Cleared only by RST. The refused byte is dropped.
//  Undefined:
//   - No o_overflow port.
//   - Refused writes are dropped silently; the producer must honour o_wr_ready.
// TESTING  (bench: TicksPerBit=4, Depth=4, GuardTicks=2 -> SlotTicks=42)
//  1. Hold RST 3 cycles -> o_send=0, o_frame=00, o_count=0, o_wr_ready=1, o_busy=0.
//  2. Write 0xA5 in cycle 0 -> o_send=1 only in cycle 2, o_frame=A5 from cycle 2 on; o_busy drops at cycle 44.
//  3. Write 0x11,0x22,0x33 back-to-back -> three o_send strobes 43 cycles apart, frames 11,22,33 in order.
//  4. Write 6 bytes in cycles 0-5 -> 5 accepted, o_wr_ready=0 in cycle 5, 6th byte never sent;
//     with OVF_EN o_overflow=1 from cycle 6 until RST.
//  5. Assert RST for 1 cycle at timer=20 with 2 bytes queued -> o_count=0, state IDLE,
//     no further o_send strobes.
//  6. With count==Depth, assert write and pop in the same IDLE cycle -> write refused, count=Depth-1.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus fixed-slot pacer that feeds a simplex UART transmitter.
// Define UART_TX_FEEDER_OVF_EN to add the sticky o_overflow flag for refused writes.
module uart_tx_feeder #(
    parameter int TicksPerBit = 434,
    parameter int Depth       = 16,
    parameter int GuardTicks  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_wr_valid,
    input  logic [7:0]              i_wr_data,
    output logic                    o_wr_ready,
    output logic                    o_send,
    output logic [7:0]              o_frame,
    output logic [$clog2(Depth):0]  o_count,
    output logic                    o_busy
`ifdef UART_TX_FEEDER_OVF_EN
    ,
    output logic                    o_overflow
`endif
);

    localparam int SlotTicks = 10 * TicksPerBit + GuardTicks;
    localparam int PtrW      = $clog2(Depth);
    localparam int CntW      = PtrW + 1;
    localparam int TimerW    = $clog2(SlotTicks);

    localparam logic [CntW-1:0]   FullCount = CntW'(Depth);
    localparam logic [TimerW-1:0] LastTick  = TimerW'(SlotTicks - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } FeederState;

    FeederState        r_state;
    FeederState        w_stateNext;
    logic [7:0]        r_mem [Depth];
    logic [PtrW-1:0]   r_rdPtr;
    logic [PtrW-1:0]   r_wrPtr;
    logic [CntW-1:0]   r_count;
    logic [TimerW-1:0] r_timer;
    logic [TimerW-1:0] w_timerNext;
    logic              r_send;
    logic              w_sendNext;
    logic [7:0]        r_frame;
    logic              w_push;
    logic              w_pop;

    // A full FIFO refuses writes even when a pop happens in the same cycle.
    assign o_wr_ready = (r_count != FullCount);
    assign w_push     = i_wr_valid && o_wr_ready;

    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        w_sendNext  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_sendNext  = 1'b1;
                    w_timerNext = '0;
                    w_stateNext = WAIT;
                end
            end
            WAIT: begin
                if (r_timer == LastTick) begin
                    w_stateNext = IDLE;
                end else begin
                    w_timerNext = r_timer + TimerW'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_send  <= 1'b0;
            r_frame <= 8'h00;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_stateNext;
            r_timer <= w_timerNext;
            r_send  <= w_sendNext;
            if (w_pop) begin
                r_frame <= r_mem[r_rdPtr];
                r_rdPtr <= r_rdPtr + PtrW'(1);
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define which entries are valid.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_wr_data;
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    logic r_overflow;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overflow <= 1'b0;
        end else if (i_wr_valid && !o_wr_ready) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow = r_overflow;
`endif

    assign o_send  = r_send;
    assign o_frame = r_frame;
    assign o_count = r_count;
    assign o_busy  = (r_state != IDLE) || (r_count != '0);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed bench with a byte scoreboard for uart_tx_feeder.
// Configured with TicksPerBit=4, Depth=4, GuardTicks=2, so one slot is 42 clocks.
module tb_uart_tx_feeder;

    localparam int TicksPerBit = 4;
    localparam int Depth       = 4;
    localparam int GuardTicks  = 2;
    localparam int SlotTicks   = 10 * TicksPerBit + GuardTicks;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       i_wr_valid = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic       o_wr_ready;
    logic       o_send;
    logic [7:0] o_frame;
    logic [2:0] o_count;
    logic       o_busy;
`ifdef UART_TX_FEEDER_OVF_EN
    logic       o_overflow;
`endif

    int         testCount = 0;
    int         failCount = 0;
    int         cycleNum = 0;
    logic [7:0] sbQueue[$];
    int         strobeTimes[$];

    uart_tx_feeder #(
        .TicksPerBit(TicksPerBit),
        .Depth(Depth),
        .GuardTicks(GuardTicks)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .i_wr_valid(i_wr_valid),
        .i_wr_data(i_wr_data),
        .o_wr_ready(o_wr_ready),
        .o_send(o_send),
        .o_frame(o_frame),
        .o_count(o_count),
        .o_busy(o_busy)
`ifdef UART_TX_FEEDER_OVF_EN
        ,
        .o_overflow(o_overflow)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleNum <= cycleNum + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit expectAccept);
        i_wr_valid = 1'b1;
        i_wr_data  = data;
        if (expectAccept) sbQueue.push_back(data);
        step();
        i_wr_valid = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, 32'(o_busy), 32'd0);
    endtask

    // Every strobe must carry the oldest byte the bench expects to be sent.
    always @(negedge CLK) begin
        if (!RST && o_send) begin
            strobeTimes.push_back(cycleNum);
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_send", 32'(o_frame), 32'hFFFF_FFFF);
            end else begin
                checkOutput("frame_order", 32'(o_frame), 32'(sbQueue.pop_front()));
            end
        end
    end

    initial begin
        int base;
        int n;

        $display("[TB] reset state");
        repeat (3) step();
        checkOutput("rst_send", 32'(o_send), 32'd0);
        checkOutput("rst_frame", 32'(o_frame), 32'h00);
        checkOutput("rst_count", 32'(o_count), 32'd0);
        checkOutput("rst_ready", 32'(o_wr_ready), 32'd1);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
`ifdef UART_TX_FEEDER_OVF_EN
        checkOutput("rst_ovf", 32'(o_overflow), 32'd0);
`endif
        RST = 1'b0;
        step();

        $display("[TB] single byte latency");
        applyStimulus(8'hA5, 1'b1);
        checkOutput("lat_send_c1", 32'(o_send), 32'd0);
        checkOutput("lat_count_c1", 32'(o_count), 32'd1);
        step();
        checkOutput("lat_send_c2", 32'(o_send), 32'd1);
        checkOutput("lat_frame_c2", 32'(o_frame), 32'hA5);
        step();
        checkOutput("lat_send_c3", 32'(o_send), 32'd0);
        checkOutput("lat_frame_c3", 32'(o_frame), 32'hA5);
        repeat (40) step();
        checkOutput("busy_c43", 32'(o_busy), 32'd1);
        step();
        checkOutput("busy_c44", 32'(o_busy), 32'd0);

        $display("[TB] back-to-back burst");
        base = strobeTimes.size();
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b1);
        n = 0;
        while (strobeTimes.size() < base + 3 && n < 300) begin
            step();
            n++;
        end
        checkOutput("burst_strobes", 32'(strobeTimes.size()), 32'(base + 3));
        if (strobeTimes.size() >= base + 3) begin
            checkOutput("burst_gap1", 32'(strobeTimes[base + 1] - strobeTimes[base]), 32'(SlotTicks + 1));
            checkOutput("burst_gap2", 32'(strobeTimes[base + 2] - strobeTimes[base + 1]), 32'(SlotTicks + 1));
        end
        waitIdle("burst_idle", 200);

        $display("[TB] overfill and full-cycle pop");
        applyStimulus(8'hB0, 1'b1);
        applyStimulus(8'hB1, 1'b1);
        applyStimulus(8'hB2, 1'b1);
        applyStimulus(8'hB3, 1'b1);
        applyStimulus(8'hB4, 1'b1);
        checkOutput("full_count_c5", 32'(o_count), 32'd4);
        checkOutput("full_ready_c5", 32'(o_wr_ready), 32'd0);
`ifdef UART_TX_FEEDER_OVF_EN
        checkOutput("ovf_c5", 32'(o_overflow), 32'd0);
`endif
        applyStimulus(8'hB5, 1'b0);
`ifdef UART_TX_FEEDER_OVF_EN
        checkOutput("ovf_c6", 32'(o_overflow), 32'd1);
`endif
        repeat (38) step();
        checkOutput("full_count_c44", 32'(o_count), 32'd4);
        checkOutput("full_send_c44", 32'(o_send), 32'd0);
        applyStimulus(8'hEE, 1'b0);
        checkOutput("pushpop_count", 32'(o_count), 32'd3);
        checkOutput("pushpop_send", 32'(o_send), 32'd1);
        checkOutput("pushpop_frame", 32'(o_frame), 32'hB1);
`ifdef UART_TX_FEEDER_OVF_EN
        checkOutput("ovf_sticky", 32'(o_overflow), 32'd1);
`endif
        waitIdle("drain_idle", 400);
        checkOutput("drain_sb_empty", 32'(sbQueue.size()), 32'd0);

        $display("[TB] reset mid-slot");
        applyStimulus(8'hC0, 1'b1);
        applyStimulus(8'hC1, 1'b1);
        applyStimulus(8'hC2, 1'b1);
        repeat (19) step();
        checkOutput("mid_busy", 32'(o_busy), 32'd1);
        checkOutput("mid_count", 32'(o_count), 32'd2);
        RST = 1'b1;
        step();
        RST = 1'b0;
        sbQueue.delete();
        checkOutput("abort_count", 32'(o_count), 32'd0);
        checkOutput("abort_busy", 32'(o_busy), 32'd0);
        checkOutput("abort_ready", 32'(o_wr_ready), 32'd1);
`ifdef UART_TX_FEEDER_OVF_EN
        checkOutput("abort_ovf", 32'(o_overflow), 32'd0);
`endif
        base = strobeTimes.size();
        repeat (100) step();
        checkOutput("abort_no_send", 32'(strobeTimes.size()), 32'(base));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
